mips_regfile_sb: RTL and testbench
==================================

# mips_regfile_sb

Parametrised successor to the MIPS register file: clocked single-write, dual-read storage with registered read ports, optional write-to-read bypass, hardwired zero register and a per-register pending-write scoreboard. It sits between decode and the pipeline's operand latches. It returns operands one cycle after a read request, together with a busy flag telling the hazard unit whether an in-flight instruction still owes that register a value.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- BYPASS, 1, 1 = same-cycle write forwarded to read data and busy flag; 0 = reads return pre-write state
- ZERO_REG, 1, 1 = entry 0 reads 0, ignores writes, never busy; 0 = entry 0 is ordinary

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- rd_en  in  1  read request, sampled at rising edge
- rd_addr1  in  ADDR_W  read port 1 address
- rd_addr2  in  ADDR_W  read port 2 address
- rd_data1  out  DATA_W  registered read data, port 1
- rd_data2  out  DATA_W  registered read data, port 2
- busy1  out  1  registered pending flag for rd_addr1
- busy2  out  1  registered pending flag for rd_addr2
- rd_valid  out  1  high for exactly one cycle after each accepted rd_en
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rsv_en  in  1  reserve: mark rsv_addr pending (issued instruction will write it)
- rsv_addr  in  ADDR_W  register to reserve

## Operation
- Storage: 2**ADDR_W x DATA_W array plus a 2**ADDR_W-bit pending vector.
- Write: on a rising edge with wr_en=1, the array entry at wr_addr takes wr_data and the pending bit at wr_addr clears. When ZERO_REG=1 and wr_addr=0, the write is dropped.
- Reserve: on a rising edge with rsv_en=1, the pending bit at rsv_addr is set. When ZERO_REG=1 and rsv_addr=0, the reserve is dropped.
- Reserve and write to the same address in the same cycle: the data is written and the pending bit ends set, because the reserve belongs to a younger instruction.
- Read: on a rising edge with rd_en=1, rd_dataN, busyN and rd_valid are loaded. When rd_en=0, rd_dataN and busyN hold their values and rd_valid drops to 0.
- Read value, evaluated per port:
  - ZERO_REG=1 and address 0: data 0, busy 0.
  - Otherwise, when BYPASS=1, wr_en=1 and wr_addr equals the read address: data is wr_data.
  - Otherwise: data is the array entry.
- Busy value, per port:
  - Equals the next-state pending bit when BYPASS=1, so a same-cycle write or reserve is reflected.
  - Equals the current pending bit when BYPASS=0.
- Both ports may read the same address; both return identical values.
- Reset: asynchronous. On assertion, all array entries, all pending bits, rd_data1/2, busy1/2 and rd_valid clear to 0 immediately. Reset overrides any operation in progress. The first accepted edge after deassertion behaves normally.

## Timing
- Read latency is 1 cycle: request at edge N, data, busy and rd_valid visible after edge N.
- Back-to-back rd_en is allowed every cycle; rd_valid stays high continuously.
- A write at edge N is visible to a read sampled at edge N when BYPASS=1, and to reads sampled at edge N+1 or later in both modes.
- A reserve at edge N shows busy=1 for a read sampled at edge N when BYPASS=1, and for reads at edge N+1 or later in both modes.
- There are no combinational paths from inputs to outputs.
- There is no back-pressure; the block never stalls.

## Test plan
- Reset: write 0xDEADBEEF to r9, assert rst mid-cycle -> all outputs 0 asynchronously; a read of r9 after release returns 0 with busy 0.
- Basic write/read: write 0x0000_00A5 to r8 at edge 1; rd_en with rd_addr1=8, rd_addr2=8 at edge 2 -> both ports return 0xA5, busy 0, rd_valid high for one cycle.
- Bypass: wr_en r17=0x1234 and rd_en rd_addr1=17 at the same edge -> BYPASS=1 returns 0x1234; BYPASS=0 returns the prior value 0, then 0x1234 on the next read.
- Zero register: write 0xFFFF_FFFF to r0 and reserve r0 -> reads of r0 return 0 with busy 0 when ZERO_REG=1; with ZERO_REG=0 the read returns 0xFFFF_FFFF.
- Scoreboard: reserve r20 at edge 1 -> read at edge 2 gives busy1=1. Write r20=7 at edge 3 -> read at edge 4 gives busy1=0 and data 7. Reserve and write r20 together -> busy stays 1 and data updates.
- Parameter sweep: DATA_W=16, ADDR_W=3 -> write 0xBEEF to r7 and read it back. Write r0, then read r0 and r7 on the two ports -> r0 returns 0, r7 returns 0xBEEF, with no aliasing from the address wrap.

Source files
------------

// File: rtl/mips_regfile_sb.sv
`default_nettype none
// ============================================================================
// mips_regfile_sb : single-write, dual-read register file with registered
// reads, optional write bypass, hardwired zero entry and pending-write bits.
// Revision: 1.0
// ============================================================================
module mips_regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              busy1,
    output logic              busy2,
    output logic              rd_valid,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;
    logic              wr_ok;
    logic              rsv_ok;
    logic [DATA_W-1:0] rd_data1_d;
    logic [DATA_W-1:0] rd_data2_d;
    logic              busy1_d;
    logic              busy2_d;

    assign wr_ok  = wr_en  && !((ZERO_REG != 0) && (wr_addr  == '0));
    assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

    // Reserve is applied after the write clear: it belongs to a younger instruction.
    always_comb begin
        pend_d = pend_q;
        if (wr_ok) begin
            pend_d[wr_addr] = 1'b0;
        end
        if (rsv_ok) begin
            pend_d[rsv_addr] = 1'b1;
        end
    end

    always_comb begin
        rd_data1_d = mem_q[rd_addr1];
        busy1_d    = (BYPASS != 0) ? pend_d[rd_addr1] : pend_q[rd_addr1];
        if ((ZERO_REG != 0) && (rd_addr1 == '0)) begin
            rd_data1_d = '0;
            busy1_d    = 1'b0;
        end else if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr1)) begin
            rd_data1_d = wr_data;
        end

        rd_data2_d = mem_q[rd_addr2];
        busy2_d    = (BYPASS != 0) ? pend_d[rd_addr2] : pend_q[rd_addr2];
        if ((ZERO_REG != 0) && (rd_addr2 == '0)) begin
            rd_data2_d = '0;
            busy2_d    = 1'b0;
        end else if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr2)) begin
            rd_data2_d = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data1 <= '0;
            rd_data2 <= '0;
            busy1    <= 1'b0;
            busy2    <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data1 <= rd_data1_d;
                rd_data2 <= rd_data2_d;
                busy1    <= busy1_d;
                busy2    <= busy2_d;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_regfile_sb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_mips_regfile_sb : scoreboard bench over three parameterisations
// (bypass+zero, no-bypass/no-zero, narrow 16x8). Revision: 1.0
// ============================================================================
module tb_mips_regfile_sb;

    typedef struct packed {
        logic [31:0] d1;
        logic [31:0] d2;
        logic        b1;
        logic        b2;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for instances A (BYPASS=1, ZERO_REG=1) and B (BYPASS=0, ZERO_REG=0)
    logic        rd_en = 0, wr_en = 0, rsv_en = 0;
    logic [4:0]  ra1 = 0, ra2 = 0, wa = 0, rsva = 0;
    logic [31:0] wd = 0;
    logic [31:0] a_d1, a_d2, b_d1, b_d2;
    logic        a_b1, a_b2, a_v, b_b1, b_b2, b_v;

    // Instance C: DATA_W=16, ADDR_W=3
    logic        c_rd_en = 0, c_wr_en = 0, c_rsv_en = 0;
    logic [2:0]  c_ra1 = 0, c_ra2 = 0, c_wa = 0, c_rsva = 0;
    logic [15:0] c_wd = 0, c_d1, c_d2;
    logic        c_b1, c_b2, c_v;

    rsp_t qa[$];
    rsp_t qb[$];
    rsp_t qc[$];
    int   total = 0;
    int   bad   = 0;

    mips_regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .ZERO_REG(1)) u_a (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr1(ra1), .rd_addr2(ra2),
        .rd_data1(a_d1), .rd_data2(a_d2), .busy1(a_b1), .busy2(a_b2), .rd_valid(a_v),
        .wr_en(wr_en), .wr_addr(wa), .wr_data(wd), .rsv_en(rsv_en), .rsv_addr(rsva));

    mips_regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0), .ZERO_REG(0)) u_b (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr1(ra1), .rd_addr2(ra2),
        .rd_data1(b_d1), .rd_data2(b_d2), .busy1(b_b1), .busy2(b_b2), .rd_valid(b_v),
        .wr_en(wr_en), .wr_addr(wa), .wr_data(wd), .rsv_en(rsv_en), .rsv_addr(rsva));

    mips_regfile_sb #(.DATA_W(16), .ADDR_W(3), .BYPASS(1), .ZERO_REG(1)) u_c (
        .clk(clk), .rst(rst), .rd_en(c_rd_en), .rd_addr1(c_ra1), .rd_addr2(c_ra2),
        .rd_data1(c_d1), .rd_data2(c_d2), .busy1(c_b1), .busy2(c_b2), .rd_valid(c_v),
        .wr_en(c_wr_en), .wr_addr(c_wa), .wr_data(c_wd), .rsv_en(c_rsv_en), .rsv_addr(c_rsva));

    function automatic rsp_t mk(input logic [31:0] d1, input logic [31:0] d2,
                                input logic b1, input logic b2);
        return {d1, d2, b1, b2};
    endfunction

    task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got rd_valid=1 expected no pending read", nm);
    endtask

    // Monitors: pop one expectation per rd_valid cycle
    always @(negedge clk) begin
        if (!rst && a_v) begin
            if (qa.size() == 0) unexpected("A valid");
            else chk("A read", mk(a_d1, a_d2, a_b1, a_b2), qa.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!rst && b_v) begin
            if (qb.size() == 0) unexpected("B valid");
            else chk("B read", mk(b_d1, b_d2, b_b1, b_b2), qb.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!rst && c_v) begin
            if (qc.size() == 0) unexpected("C valid");
            else chk("C read", mk({16'h0, c_d1}, {16'h0, c_d2}, c_b1, c_b2), qc.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rd_en = 0; wr_en = 0; rsv_en = 0;
        c_rd_en = 0; c_wr_en = 0; c_rsv_en = 0;
    endtask

    task automatic push_ab(input rsp_t ea, input rsp_t eb);
        qa.push_back(ea);
        qb.push_back(eb);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " A out"}, {mk(a_d1, a_d2, a_b1, a_b2), a_v}, '0);
        chk({tag, " B out"}, {mk(b_d1, b_d2, b_b1, b_b2), b_v}, '0);
        chk({tag, " C out"}, {mk({16'h0, c_d1}, {16'h0, c_d2}, c_b1, c_b2), c_v}, '0);
    endtask

    initial begin
        #2 rst = 1'b1;
        #1 chk_all_zero("initial reset");
        @(negedge clk);
        rst = 1'b0;

        // Basic write then read, both ports same address; narrow instance in parallel
        wr_en = 1; wa = 8; wd = 32'h0000_00A5;
        c_wr_en = 1; c_wa = 7; c_wd = 16'hBEEF;
        tick();
        rd_en = 1; ra1 = 8; ra2 = 8;
        push_ab(mk(32'hA5, 32'hA5, 0, 0), mk(32'hA5, 32'hA5, 0, 0));
        c_rd_en = 1; c_ra1 = 7; c_ra2 = 7;
        qc.push_back(mk(32'hBEEF, 32'hBEEF, 0, 0));
        tick();

        // Narrow: r0 write dropped, no aliasing onto r7
        c_wr_en = 1; c_wa = 0; c_wd = 16'h1234;
        tick();
        c_rd_en = 1; c_ra1 = 0; c_ra2 = 7;
        qc.push_back(mk(32'h0, 32'hBEEF, 0, 0));
        tick();
        c_wr_en = 1; c_wa = 0; c_wd = 16'h5555;
        c_rd_en = 1; c_ra1 = 0; c_ra2 = 0;
        qc.push_back(mk(32'h0, 32'h0, 0, 0));
        tick();

        // Same-edge write and read: bypass vs. pre-write state, then back-to-back read
        wr_en = 1; wa = 17; wd = 32'h1234;
        rd_en = 1; ra1 = 17; ra2 = 8;
        push_ab(mk(32'h1234, 32'hA5, 0, 0), mk(32'h0, 32'hA5, 0, 0));
        tick();
        rd_en = 1; ra1 = 17; ra2 = 17;
        push_ab(mk(32'h1234, 32'h1234, 0, 0), mk(32'h1234, 32'h1234, 0, 0));
        tick();

        // Write and reserve r0 together
        wr_en = 1; wa = 0; wd = 32'hFFFF_FFFF; rsv_en = 1; rsva = 0;
        tick();
        rd_en = 1; ra1 = 0; ra2 = 0;
        push_ab(mk(32'h0, 32'h0, 0, 0), mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1));
        tick();

        // Pending-write bit on r20
        rsv_en = 1; rsva = 20;
        tick();
        rd_en = 1; ra1 = 20; ra2 = 0;
        push_ab(mk(32'h0, 32'h0, 1, 0), mk(32'h0, 32'hFFFF_FFFF, 1, 1));
        tick();
        wr_en = 1; wa = 20; wd = 32'h7;
        tick();
        rd_en = 1; ra1 = 20; ra2 = 0;
        push_ab(mk(32'h7, 32'h0, 0, 0), mk(32'h7, 32'hFFFF_FFFF, 0, 1));
        tick();
        rsv_en = 1; rsva = 20; wr_en = 1; wa = 20; wd = 32'h9;
        rd_en = 1; ra1 = 20; ra2 = 0;
        push_ab(mk(32'h9, 32'h0, 1, 0), mk(32'h7, 32'hFFFF_FFFF, 0, 1));
        tick();
        rd_en = 1; ra1 = 20; ra2 = 0;
        push_ab(mk(32'h9, 32'h0, 1, 0), mk(32'h9, 32'hFFFF_FFFF, 1, 1));
        tick();

        // Same-edge reserve seen by busy only with bypass
        rsv_en = 1; rsva = 5;
        rd_en = 1; ra1 = 5; ra2 = 20;
        push_ab(mk(32'h0, 32'h9, 1, 1), mk(32'h0, 32'h9, 0, 1));
        tick();

        // Outputs hold while idle; rd_valid low
        tick();
        tick();
        @(negedge clk);
        chk("A hold", mk(a_d1, a_d2, a_b1, a_b2), mk(32'h0, 32'h9, 1, 1));
        chk("B hold", mk(b_d1, b_d2, b_b1, b_b2), mk(32'h0, 32'h9, 0, 1));
        chk("A valid idle", {65'h0, a_v}, '0);

        // Asynchronous reset mid-cycle after r9 is written and read
        #1;
        wr_en = 1; wa = 9; wd = 32'hDEAD_BEEF;
        tick();
        rd_en = 1; ra1 = 9; ra2 = 9;
        push_ab(mk(32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0), mk(32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0));
        tick();
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_all_zero("async reset");
        @(negedge clk);
        rst = 1'b0;

        rd_en = 1; ra1 = 9; ra2 = 20;
        push_ab(mk(32'h0, 32'h0, 0, 0), mk(32'h0, 32'h0, 0, 0));
        c_rd_en = 1; c_ra1 = 7; c_ra2 = 7;
        qc.push_back(mk(32'h0, 32'h0, 0, 0));
        tick();
        rd_en = 1; ra1 = 5; ra2 = 0;
        push_ab(mk(32'h0, 32'h0, 0, 0), mk(32'h0, 32'h0, 0, 0));
        tick();

        tick();
        tick();
        @(negedge clk);
        chk("A drained", 66'(qa.size()), '0);
        chk("B drained", 66'(qb.size()), '0);
        chk("C drained", 66'(qc.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
